// File: rtl/wb_daq_vector_reader_pkg.sv
// Shared types and descriptor layout for the DAQ vector reader.
package wb_daq_vector_reader_pkg;

  localparam int unsigned CNT_W = 16;

  // Descriptor word offsets; the DAQ write-side master uses the same layout.
  localparam int unsigned VECTOR_READ_POINTER_OFFSET  = 32'h0;
  localparam int unsigned VECTOR_WRITE_POINTER_OFFSET = 32'h4;
  localparam int unsigned VECTOR_START_ADDRESS_OFFSET = 32'h8;
  localparam int unsigned VECTOR_END_ADDRESS_OFFSET   = 32'hC;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_RPTR,
    S_RD_WPTR,
    S_RD_START,
    S_RD_END,
    S_CALC,
    S_READ,
    S_PUSH,
    S_WR_RPTR,
    S_ERROR,
    S_DONE
  } state_e;

endpackage

// File: rtl/wb_daq_vector_reader.sv
// Wishbone master draining DAQ samples from a circular vector buffer.
// Optional feature: WB_DAQ_READER_RETRY_EN (reissue on wb_rty_i up to MAX_RETRY).
module wb_daq_vector_reader
  import wb_daq_vector_reader_pkg::*;
#(
  parameter int unsigned dw        = 32,
  parameter int unsigned aw        = 32,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  output logic [aw-1:0]    wb_adr_o,
  output logic [dw-1:0]    wb_dat_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [2:0]       wb_cti_o,
  output logic [1:0]       wb_bte_o,
  input  logic [dw-1:0]    wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i,
  input  logic             start,
  input  logic [aw-1:0]    address,
  input  logic [CNT_W-1:0] count,
  output logic [dw-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_read
);

`ifdef WB_DAQ_READER_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif
  localparam int unsigned RTRY_W = $clog2(MAX_RETRY + 2);

  state_e               state_q, state_d;
  logic [aw-1:0]        adr_q, adr_d;
  logic [dw-1:0]        dat_q, dat_d;
  logic                 we_q, we_d;
  logic                 cyc_q, cyc_d;
  logic [aw-1:0]        base_q, base_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [aw-1:0]        rd_q, rd_d;
  logic [aw-1:0]        wr_q, wr_d;
  logic [aw-1:0]        start_q, start_d;
  logic [aw-1:0]        end_q, end_d;
  logic [CNT_W-1:0]     xfer_q, xfer_d;
  logic [CNT_W-1:0]     words_q, words_d;
  logic [dw-1:0]        out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [RTRY_W-1:0]    retry_q, retry_d;

  logic                 acc_en_c;
  logic [aw-1:0]        acc_adr_c;
  logic [dw-1:0]        acc_dat_c;
  logic                 acc_we_c;
  logic [aw-1:0]        ring_words_c;
  logic [aw-1:0]        avail_c;
  logic [CNT_W-1:0]     avail_sat_c;
  logic [CNT_W-1:0]     xfer_c;
  logic [aw-1:0]        rd_inc_c;
  logic [CNT_W-1:0]     words_inc_c;

  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_sel_o   = {4{cyc_q}};
  assign wb_cti_o   = 3'b000;
  assign wb_bte_o   = 2'b00;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign words_read = words_q;

  // Address, direction and write data of the access owned by the current state.
  always_comb begin
    acc_en_c  = 1'b1;
    acc_adr_c = rd_q;
    acc_dat_c = '0;
    acc_we_c  = 1'b0;
    unique case (state_q)
      S_RD_RPTR:  acc_adr_c = base_q + aw'(VECTOR_READ_POINTER_OFFSET);
      S_RD_WPTR:  acc_adr_c = base_q + aw'(VECTOR_WRITE_POINTER_OFFSET);
      S_RD_START: acc_adr_c = base_q + aw'(VECTOR_START_ADDRESS_OFFSET);
      S_RD_END:   acc_adr_c = base_q + aw'(VECTOR_END_ADDRESS_OFFSET);
      S_READ:     acc_adr_c = rd_q;
      S_WR_RPTR: begin
        acc_adr_c = base_q + aw'(VECTOR_READ_POINTER_OFFSET);
        acc_dat_c = dw'(rd_q);
        acc_we_c  = 1'b1;
      end
      default:    acc_en_c  = 1'b0;
    endcase
  end

  // Occupancy of the ring and the transfer length, saturated to 16 bits.
  always_comb begin
    ring_words_c = ((end_q - start_q) >> 2) + aw'(1);
    avail_c      = (wr_q >= rd_q) ? ((wr_q - rd_q) >> 2)
                                  : (ring_words_c - ((rd_q - wr_q) >> 2));
    avail_sat_c  = (avail_c > aw'(16'hFFFF)) ? 16'hFFFF : avail_c[CNT_W-1:0];
    xfer_c       = (count_q < avail_sat_c) ? count_q : avail_sat_c;
    rd_inc_c     = rd_q + aw'(4);
    words_inc_c  = words_q + CNT_W'(1);
  end

  // Next-state logic: bus handshake, descriptor fetch, streaming and writeback.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    base_d      = base_q;
    count_d     = count_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    start_d     = start_q;
    end_d       = end_q;
    xfer_d      = xfer_q;
    words_d     = words_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    error_d     = error_q;
    retry_d     = retry_q;
    done_d      = 1'b0;

    if (acc_en_c) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        adr_d = acc_adr_c;
        dat_d = acc_dat_c;
        we_d  = acc_we_c;
      end else if (wb_ack_i) begin
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        retry_d = '0;
        unique case (state_q)
          S_RD_RPTR:  begin rd_d    = aw'(wb_dat_i); state_d = S_RD_WPTR;  end
          S_RD_WPTR:  begin wr_d    = aw'(wb_dat_i); state_d = S_RD_START; end
          S_RD_START: begin start_d = aw'(wb_dat_i); state_d = S_RD_END;   end
          S_RD_END:   begin end_d   = aw'(wb_dat_i); state_d = S_CALC;     end
          S_READ: begin
            out_data_d  = wb_dat_i;
            out_valid_d = 1'b1;
            state_d     = S_PUSH;
          end
          default:    state_d = S_DONE;
        endcase
      end else if (wb_err_i || wb_rty_i) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        // A retry drops the cycle and the same state reissues the access.
        if (RetryEn && wb_rty_i && !wb_err_i && (retry_q < RTRY_W'(MAX_RETRY))) begin
          retry_d = retry_q + RTRY_W'(1);
        end else begin
          retry_d = '0;
          state_d = S_ERROR;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = address;
          count_d = count;
          words_d = '0;
          error_d = 1'b0;
          retry_d = '0;
          busy_d  = 1'b1;
          state_d = S_RD_RPTR;
        end
      end
      S_CALC: begin
        xfer_d  = xfer_c;
        state_d = (xfer_c == '0) ? S_DONE : S_READ;
      end
      S_PUSH: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          rd_d        = (rd_inc_c > end_q) ? start_q : rd_inc_c;
          words_d     = words_inc_c;
          state_d     = (words_inc_c < xfer_q) ? S_READ : S_WR_RPTR;
        end
      end
      S_ERROR: begin
        error_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q     <= S_IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      base_q      <= '0;
      count_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      start_q     <= '0;
      end_q       <= '0;
      xfer_q      <= '0;
      words_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      base_q      <= base_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      start_q     <= start_d;
      end_q       <= end_d;
      xfer_q      <= xfer_d;
      words_q     <= words_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      retry_q     <= retry_d;
    end
  end

endmodule

// File: tb/tb_wb_daq_vector_reader.sv
// Testbench for wb_daq_vector_reader: WB memory slave, streaming consumer, scoreboard.
module tb_wb_daq_vector_reader;

  logic        clk, rst_n;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic        start;
  logic [31:0] address;
  logic [15:0] count;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic        busy, done, error;
  logic [15:0] words_read;

  wb_daq_vector_reader #(.dw(32), .aw(32), .MAX_RETRY(3)) dut (
    .wb_clk(clk), .wb_rst(rst_n),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .start(start), .address(address), .count(count),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error), .words_read(words_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] BASE = 32'h100;
  localparam logic [31:0] RING_START = 32'h1000;
  localparam logic [31:0] RING_END   = 32'h103C;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] wr;
    logic [15:0] cnt;
    int          stall_word;
    int          fault_idx;
    int          fault_kind;
    int          fault_n;
    bit          restart;
    bit          start_at_done;
    int          exp_words;
    bit          exp_wb;
    logic [31:0] exp_ptr;
    bit          exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q [$];
  logic [31:0] flt_log [$];
  logic [63:0] wr_log [$];
  int desc_reads, stray_reads, data_idx;
  int fault_idx, fault_kind, fault_left;
  int widx, stall_word, stall_left;
  logic [31:0] held;
  bit cons_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory slave: answers each access one half-cycle after it appears.
  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    if (rst_n && wb_cyc_o && wb_stb_o) begin
      chk("wb_sel", 32'(wb_sel_o), 32'hF);
      if (!wb_we_o && wb_adr_o >= RING_START && data_idx == fault_idx && fault_left > 0) begin
        fault_left--;
        flt_log.push_back(wb_adr_o);
        if (fault_kind == 1) wb_rty_i = 1'b1;
        else wb_err_i = 1'b1;
      end else begin
        wb_ack_i = 1'b1;
        if (wb_we_o) begin
          mem[wb_adr_o] = wb_dat_o;
          wr_log.push_back({wb_adr_o, wb_dat_o});
        end else begin
          wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : (32'hD000_0000 | wb_adr_o);
          if (wb_adr_o >= RING_START) data_idx++;
          else if (wb_adr_o >= BASE && wb_adr_o <= BASE + 32'hC) desc_reads++;
          else stray_reads++;
        end
      end
    end
  end

  // Consumer: pops the scoreboard on each handshake, optionally stalls one word.
  always @(negedge clk) begin
    if (rst_n && cons_en) begin
      if (stall_left > 0) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, held);
        chk("stall_no_cyc", 32'(wb_cyc_o), 32'd0);
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end else if (out_valid && !out_ready && widx == stall_word) begin
        held = out_data;
        stall_left = 10;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", out_data, 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("word%0d", widx), out_data, exp_q.pop_front());
        end
        widx++;
        if (widx == stall_word) out_ready = 1'b0;
      end
    end
  end

  function automatic vec_t mk(logic [31:0] rd, logic [31:0] wr, logic [15:0] cnt,
                              int sw, int fi, int fk, int fn, bit rs, bit sad,
                              int ew, bit ewb, logic [31:0] ep, bit ee);
    vec_t v;
    v.rd = rd; v.wr = wr; v.cnt = cnt; v.stall_word = sw;
    v.fault_idx = fi; v.fault_kind = fk; v.fault_n = fn;
    v.restart = rs; v.start_at_done = sad;
    v.exp_words = ew; v.exp_wb = ewb; v.exp_ptr = ep; v.exp_err = ee;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    logic [31:0] a, fa;
    bit got;
    int idle_cyc;
    mem.delete();
    mem[BASE]        = v.rd;
    mem[BASE + 4]    = v.wr;
    mem[BASE + 8]    = RING_START;
    mem[BASE + 32'hC] = RING_END;
    wr_log.delete(); flt_log.delete(); exp_q.delete();
    desc_reads = 0; stray_reads = 0; data_idx = 0;
    fault_idx = v.fault_idx; fault_kind = v.fault_kind; fault_left = v.fault_n;
    a = v.rd; fa = 32'h0;
    for (int i = 0; i < 64; i++) begin
      if (i == v.fault_idx) fa = a;
      if (i < v.exp_words) exp_q.push_back(32'hD000_0000 | a);
      a = a + 32'd4;
      if (a > RING_END) a = RING_START;
    end
    widx = 0; stall_word = v.stall_word; stall_left = 0;
    out_ready = (v.stall_word != 0);
    cons_en = 1'b1;

    @(negedge clk);
    start = 1'b1; address = BASE; count = v.cnt;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d busy_after_start", id), 32'(busy), 32'd1);
    chk($sformatf("v%0d error_cleared", id), 32'(error), 32'd0);

    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (v.restart && c == 2) begin start = 1'b1; address = 32'h200; count = 16'd1; end
      else if (v.restart && c == 3) begin start = 1'b0; address = BASE; end
      if (done) begin got = 1'b1; break; end
    end
    chk($sformatf("v%0d done_seen", id), 32'(got), 32'd1);
    chk($sformatf("v%0d error", id), 32'(error), 32'(v.exp_err));
    chk($sformatf("v%0d words_read", id), 32'(words_read), 32'(v.exp_words));
    if (v.start_at_done) begin start = 1'b1; address = BASE; count = 16'd4; end
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d done_pulse", id), 32'(done), 32'd0);
    chk($sformatf("v%0d busy_clear", id), 32'(busy), 32'd0);
    idle_cyc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wb_cyc_o || busy) idle_cyc++;
    end
    chk($sformatf("v%0d stays_idle", id), 32'(idle_cyc), 32'd0);
    chk($sformatf("v%0d words_hold", id), 32'(words_read), 32'(v.exp_words));
    chk($sformatf("v%0d words_left", id), 32'(exp_q.size()), 32'd0);
    chk($sformatf("v%0d desc_reads", id), 32'(desc_reads), 32'd4);
    chk($sformatf("v%0d stray_reads", id), 32'(stray_reads), 32'd0);
    chk($sformatf("v%0d writebacks", id), 32'(wr_log.size()), 32'(v.exp_wb));
    if (v.exp_wb && wr_log.size() > 0) begin
      chk($sformatf("v%0d wb_addr", id), wr_log[0][63:32], BASE);
      chk($sformatf("v%0d wb_ptr", id), wr_log[0][31:0], v.exp_ptr);
    end
    foreach (flt_log[k]) chk($sformatf("v%0d fault_addr%0d", id, k), flt_log[k], fa);
    cons_en = 1'b0;
  endtask

  vec_t vecs [11];

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; address = '0; count = '0; out_ready = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    cons_en = 1'b0; fault_idx = -1; fault_kind = 0; fault_left = 0;
    desc_reads = 0; stray_reads = 0; data_idx = 0;
    widx = 0; stall_word = -1; stall_left = 0; held = '0;

    //            rd        wr        cnt  stall fi fk fn rs sad ew  wb ptr       err
    vecs[0]  = mk(32'h1000, 32'h1010, 8,   -1,  -1, 0, 0, 1, 0,  4,  1, 32'h1010, 0);
    vecs[1]  = mk(32'h1038, 32'h1008, 16,  -1,  -1, 0, 0, 0, 0,  4,  1, 32'h1008, 0);
    vecs[2]  = mk(32'h1020, 32'h1020, 5,   -1,  -1, 0, 0, 0, 1,  0,  0, 32'h0,    0);
    vecs[3]  = mk(32'h1000, 32'h1010, 0,   -1,  -1, 0, 0, 0, 0,  0,  0, 32'h0,    0);
    vecs[4]  = mk(32'h1000, 32'h1030, 3,   -1,  -1, 0, 0, 0, 0,  3,  1, 32'h100C, 0);
    vecs[5]  = mk(32'h1000, 32'h1010, 8,   1,   -1, 0, 0, 0, 0,  4,  1, 32'h1010, 0);
    vecs[6]  = mk(32'h1000, 32'h1020, 8,   -1,  2,  0, 1, 0, 0,  2,  0, 32'h0,    1);
    vecs[7]  = mk(32'h1030, 32'h1000, 16,  -1,  -1, 0, 0, 0, 0,  4,  1, 32'h1000, 0);
    vecs[8]  = mk(32'h1004, 32'h1000, 20,  -1,  -1, 0, 0, 0, 1,  15, 1, 32'h1000, 0);
`ifdef WB_DAQ_READER_RETRY_EN
    vecs[9]  = mk(32'h1000, 32'h1010, 8,   -1,  0,  1, 2, 0, 0,  4,  1, 32'h1010, 0);
`else
    vecs[9]  = mk(32'h1000, 32'h1010, 8,   -1,  0,  1, 2, 0, 0,  0,  0, 32'h0,    1);
`endif
    vecs[10] = mk(32'h1000, 32'h1010, 8,   -1,  0,  1, 4, 0, 0,  0,  0, 32'h0,    1);

    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
    chk("rst_words", 32'(words_read), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cti_bte", {27'd0, wb_cti_o, wb_bte_o}, 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset during a data read drops the cycle at once and leaves no writeback.
    mem[BASE] = 32'h1000; mem[BASE + 4] = 32'h1010;
    wr_log.delete(); exp_q.delete();
    fault_idx = -1; fault_left = 0; data_idx = 0;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; address = BASE; count = 16'd8;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (wb_cyc_o && wb_adr_o >= RING_START) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("midrst_read_seen", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_cyc_async", 32'(wb_cyc_o), 32'd0);
    chk("midrst_stb_async", 32'(wb_stb_o), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_writeback", 32'(wr_log.size()), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_idle", {30'd0, busy, wb_cyc_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
